// File: rtl/cpu_pkg.sv
// Shared CPU debug constants: register-file geometry, dump framing byte and dump FSM states.
package cpu_pkg;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 2;
  localparam int NUM_REGS = 4;
  // One extra count so the walk index can hold its terminal value.
  localparam int IDX_W    = $clog2(NUM_REGS + 1);

  localparam logic [DATA_W-1:0] DUMP_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    DS_IDLE,
    DS_CAPTURE,
    DS_SEND_HDR,
    DS_SEND_REG,
    DS_SEND_SUM
  } dump_state_t;
endpackage

// File: rtl/reg_dump_reader.sv
// Snapshots R0..R3 through one read port, then streams header, R0..R3, checksum; header 5 cycles after start.
// Output is a registered stage: while valid && !ready, data/last hold and valid stays high.
module reg_dump_reader
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done
);

  dump_state_t       state, state_n;
  logic [IDX_W-1:0]  index, index_n, index_inc;
  logic [DATA_W-1:0] sum, sum_n;
  logic [DATA_W-1:0] out_data_n;
  logic              out_valid_n, out_last_n, done_n;
  logic [DATA_W-1:0] snap [NUM_REGS];
  logic              xfer;

  assign xfer         = out_valid && out_ready;
  assign busy         = (state != DS_IDLE);
  assign index_inc    = index + IDX_W'(1);
  assign rf_read_addr = (state == DS_CAPTURE) ? index[ADDR_W-1:0] : '0;

  always_comb begin
    state_n     = state;
    index_n     = index;
    sum_n       = sum;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    out_last_n  = out_last;
    done_n      = 1'b0;
    case (state)
      DS_IDLE: begin
        if (start) begin
          state_n = DS_CAPTURE;
          index_n = '0;
          sum_n   = DUMP_HEADER;
        end
      end
      DS_CAPTURE: begin
        sum_n = sum + rf_read_data;
        if (index == IDX_W'(NUM_REGS - 1)) begin
          state_n     = DS_SEND_HDR;
          index_n     = '0;
          out_valid_n = 1'b1;
          out_data_n  = DUMP_HEADER;
          out_last_n  = 1'b0;
        end else begin
          index_n = index_inc;
        end
      end
      DS_SEND_HDR: begin
        if (xfer) begin
          state_n    = DS_SEND_REG;
          out_data_n = snap[0];
        end
      end
      DS_SEND_REG: begin
        if (xfer) begin
          if (index == IDX_W'(NUM_REGS - 1)) begin
            // Negated running sum makes the whole frame add to zero.
            state_n    = DS_SEND_SUM;
            out_data_n = DATA_W'(0) - sum;
            out_last_n = 1'b1;
          end else begin
            index_n    = index_inc;
            out_data_n = snap[index_inc[ADDR_W-1:0]];
          end
        end
      end
      DS_SEND_SUM: begin
        if (xfer) begin
          state_n     = DS_IDLE;
          out_valid_n = 1'b0;
          out_last_n  = 1'b0;
          out_data_n  = '0;
          done_n      = 1'b1;
        end
      end
      default: begin
        state_n     = DS_IDLE;
        out_valid_n = 1'b0;
        out_last_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= DS_IDLE;
      index     <= '0;
      sum       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      index     <= index_n;
      sum       <= sum_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      out_last  <= out_last_n;
      done      <= done_n;
    end
  end

  // Snapshot buffer carries no reset; it is always refilled before being sent.
  always_ff @(posedge clk) begin
    if (state == DS_CAPTURE) begin
      snap[index[ADDR_W-1:0]] <= rf_read_data;
    end
  end

endmodule
